// File: rtl/dma_txfifo_demux.sv
// Demultiplexes the sys-side TX FIFO stream into per-queue CPU writes.
// Request words pick a target queue (tx) or raise a DMA RX request (rx).
module dma_txfifo_demux #(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int NUM_CPU_QUEUES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      txfifo_empty,
  input  logic [DMA_DATA_WIDTH+4:0] txfifo_rd_data,
  output logic                      txfifo_rd_inc,
  output logic [NUM_CPU_QUEUES-1:0] out_wr,
  output logic [DMA_DATA_WIDTH-1:0] out_data,
  output logic                      out_eop,
  output logic [1:0]                out_bytecnt,
  input  logic [NUM_CPU_QUEUES-1:0] out_rdy,
  output logic                      rx_req,
  output logic [3:0]                rx_req_q_id,
  input  logic                      rx_req_ack,
  output logic [7:0]                err_cnt,
  output logic [1:0]                dbg_state
);

  localparam int W = DMA_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_DATA = 2'd1,
    RX_WAIT = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic       head_fmt, head_bit3, head_q_ok, unused_bits;
  logic [1:0] head_bc;
  logic [3:0] head_q;
  logic [3:0] q_id_r;
  logic       rdy_sel, err_evt, tx_pop, req_tx_pop, req_rx_pop;
  logic [NUM_CPU_QUEUES-1:0] q_onehot;

  // Handshake: the FIFO head is valid whenever txfifo_empty is low and is
  // consumed in any cycle txfifo_rd_inc is high; a CPU queue write is only
  // issued for a word popped while that queue's out_rdy was high.
  assign head_fmt    = txfifo_rd_data[W+4];
  assign head_bit3   = txfifo_rd_data[W+3];
  assign head_bc     = txfifo_rd_data[W+2:W+1];
  assign unused_bits = txfifo_rd_data[W];
  assign head_q      = txfifo_rd_data[3:0];
  assign head_q_ok   = int'(head_q) < NUM_CPU_QUEUES;
  assign dbg_state   = state;

  always_comb begin
    rdy_sel  = 1'b0;
    q_onehot = '0;
    for (int i = 0; i < NUM_CPU_QUEUES; i++) begin
      if (q_id_r == 4'(i)) begin
        rdy_sel     = out_rdy[i];
        q_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    txfifo_rd_inc = 1'b0;
    err_evt       = 1'b0;
    case (state)
      IDLE: begin
        if (!txfifo_empty) begin
          txfifo_rd_inc = 1'b1;
          if (head_fmt) begin
            if (head_bit3) begin
              state_nxt = RX_WAIT;
            end else if (head_q_ok) begin
              state_nxt = TX_DATA;
            end else begin
              state_nxt = DROP;
              err_evt   = 1'b1;
            end
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (!txfifo_empty) begin
          // A request here means the packet was truncated; leave it for IDLE.
          if (head_fmt) begin
            err_evt   = 1'b1;
            state_nxt = IDLE;
          end else if (rdy_sel) begin
            txfifo_rd_inc = 1'b1;
            if (head_bit3) state_nxt = IDLE;
          end
        end
      end
      RX_WAIT: begin
        if (rx_req_ack) state_nxt = IDLE;
      end
      DROP: begin
        if (!txfifo_empty) begin
          if (head_fmt) begin
            state_nxt = IDLE;
          end else begin
            txfifo_rd_inc = 1'b1;
            if (head_bit3) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) txfifo_rd_inc = 1'b0;
  end

  assign tx_pop     = (state == TX_DATA) && txfifo_rd_inc;
  assign req_tx_pop = (state == IDLE) && txfifo_rd_inc && head_fmt && !head_bit3;
  assign req_rx_pop = (state == IDLE) && txfifo_rd_inc && head_fmt && head_bit3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_id_r      <= '0;
      out_wr      <= '0;
      out_data    <= '0;
      out_eop     <= 1'b0;
      out_bytecnt <= '0;
      rx_req      <= 1'b0;
      rx_req_q_id <= '0;
      err_cnt     <= '0;
    end else begin
      if (req_tx_pop) q_id_r <= head_q;
      out_wr <= tx_pop ? q_onehot : '0;
      if (tx_pop) begin
        out_data    <= txfifo_rd_data[W-1:0];
        out_eop     <= head_bit3;
        out_bytecnt <= head_bc;
      end
      if (req_rx_pop) begin
        rx_req      <= 1'b1;
        rx_req_q_id <= head_q;
      end else if (state == RX_WAIT && rx_req_ack) begin
        rx_req <= 1'b0;
      end
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
